axis_stream_checker: RTL and testbench
======================================

AXIS_STREAM_CHECKER -- requirements
Module: axis_stream_checker

Interface
REQ-001 Parameter WIDTH, default 32: data word width of both input streams.
REQ-002 Parameter DEPTH, default 33: maximum words per stream; CNT_W = $clog2(DEPTH+1).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 start  input  1  one-cycle pulse; arms a new comparison run.
REQ-006 act_next_data  output  1  consume strobe to the stream under test.
REQ-007 act_in  input  WIDTH  word from the stream under test.
REQ-008 act_valid  input  1  act_in valid.
REQ-009 act_last  input  1  act_in is the final word.
REQ-010 exp_next_data  output  1  consume strobe to the golden stream (a ROM-reader data stream bus).
REQ-011 exp_in  input  WIDTH  golden word.
REQ-012 exp_valid  input  1  exp_in valid.
REQ-013 exp_last  input  1  exp_in is the final golden word.
REQ-014 busy  output  1  high while in RUNNING.
REQ-015 done  output  1  one-cycle pulse after the run terminates.
REQ-016 pass  output  1  run result; meaningful from the done pulse until the next start.
REQ-017 err_count  output  CNT_W  number of mismatching word pairs.
REQ-018 first_err_idx  output  CNT_W  index of the first mismatching pair.
REQ-019 first_err_valid  output  1  first_err_idx holds a captured index.
REQ-020 length_err  output  1  the two streams did not end on the same word, or the run overran DEPTH.

Function
REQ-021 The FSM SHALL have two states, IDLE and RUNNING; IDLE goes to RUNNING on start, and RUNNING goes to IDLE on the terminating transfer.
REQ-022 start received in IDLE SHALL clear err_count, first_err_idx, first_err_valid, length_err, pass and the word counter in the same clock edge.
REQ-023 start received while in RUNNING SHALL be ignored.
REQ-024 act_next_data and exp_next_data SHALL both be combinationally equal to (state==RUNNING && act_valid && exp_valid), so both streams always advance together.
REQ-025 A transfer is a cycle in which the strobe of REQ-024 is high; no word SHALL be consumed from either stream outside a transfer.
REQ-026 On each transfer the pair SHALL mismatch if act_in != exp_in (full WIDTH compare).
REQ-027 On each mismatching transfer, err_count SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-028 On the first mismatch of a run, first_err_idx SHALL load the current word index and first_err_valid SHALL set; later mismatches SHALL leave both unchanged.
REQ-029 The word index SHALL start at 0 and increment on each transfer.
REQ-030 The transfer that terminates the run is the one where act_last or exp_last is high, or where the word index equals DEPTH-1.
REQ-031 On the terminating transfer, length_err SHALL set if act_last != exp_last, or if both are low.
REQ-032 done SHALL be high for exactly one cycle, the cycle after the terminating transfer.
REQ-033 pass SHALL update in the same cycle as done, to (err_count==0 && !length_err) including the final pair, and SHALL hold until the next start.
REQ-034 busy SHALL equal (state==RUNNING).
REQ-035 Valid signals dropping mid-run SHALL only stall the run, with no timeout.

Reset
REQ-036 While rst==0, the block SHALL force state IDLE, counter 0, and busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_valid=0, length_err=0 immediately, independent of clk.
REQ-037 Reset asserted mid-run SHALL abandon the run without a done pulse; after release the block SHALL wait for a new start.

Verification
REQ-038 Streams identical, DEPTH=33, last on word 32 on both, valids always high -> 33 transfers, done one cycle after word 32, pass=1, err_count=0, length_err=0.
REQ-039 act word 5 = 0xDEADBEEF, act word 9 differs from golden, all others equal -> err_count=2, first_err_idx=5, first_err_valid=1, pass=0.
REQ-040 act_last asserted on word 20 while exp_last is on word 32 -> run ends at word 20, length_err=1, pass=0, done pulse follows word 20.
REQ-041 Random independent valid gaps on both streams, identical data -> no word consumed unless both valid, pass=1, transfer count=33.
REQ-042 rst pulled low at word 10, then released, then start -> outputs zero during reset, no done for the aborted run, new run passes normally.
REQ-043 start pulsed again at word 4 of a run -> ignored; counts continue and the final result matches an undisturbed run.

Source files
------------

// File: rtl/axis_stream_checker.sv
// Compares a stream under test against a golden stream word by word, consuming
// both in lockstep, and reports mismatch count, first mismatch index and length errors.
module axis_stream_checker #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 33,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             act_next_data,
  input  logic [WIDTH-1:0] act_in,
  input  logic             act_valid,
  input  logic             act_last,
  output logic             exp_next_data,
  input  logic [WIDTH-1:0] exp_in,
  input  logic             exp_valid,
  input  logic             exp_last,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_valid,
  output logic             length_err
);

  typedef enum logic {IDLE, RUNNING} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] err_next;
  logic             xfer, term, mismatch, len_bad;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    xfer     = (state_q == RUNNING) && act_valid && exp_valid;
    mismatch = (act_in != exp_in);
    term     = xfer && (act_last || exp_last || (idx_q == LAST_IDX));
    // Both low means the run hit DEPTH without either stream ending.
    len_bad  = (act_last != exp_last) || (!act_last && !exp_last);
    err_next = (xfer && mismatch) ? sat_inc(err_count) : err_count;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUNNING;
      RUNNING: if (term)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q == RUNNING);
    act_next_data = xfer;
    exp_next_data = xfer;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q           <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
      length_err      <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state_q == IDLE) && start) begin
        idx_q           <= '0;
        pass            <= 1'b0;
        err_count       <= '0;
        first_err_idx   <= '0;
        first_err_valid <= 1'b0;
        length_err      <= 1'b0;
      end else if (xfer) begin
        err_count <= err_next;
        idx_q     <= idx_q + 1'b1;
        if (mismatch && !first_err_valid) begin
          first_err_idx   <= idx_q;
          first_err_valid <= 1'b1;
        end
        if (term) begin
          length_err <= len_bad;
          pass       <= (err_next == '0) && !len_bad;
          done       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_stream_checker.sv
// Directed scenarios with random data and valid gaps, checked against a
// per-run reference result computed from the stream contents.
module tb_axis_stream_checker;

  localparam int WIDTH = 32;
  localparam int DEPTH = 33;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BUDGET = 2000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             act_next_data, exp_next_data;
  logic [WIDTH-1:0] act_in = '0, exp_in = '0;
  logic             act_valid = 1'b0, exp_valid = 1'b0;
  logic             act_last = 1'b0, exp_last = 1'b0;
  logic             busy, done, pass, first_err_valid, length_err;
  logic [CNT_W-1:0] err_count, first_err_idx;

  int n_asserts = 0;
  int n_fails = 0;

  logic [WIDTH-1:0] act_mem [DEPTH];
  logic [WIDTH-1:0] exp_mem [DEPTH];
  int act_last_pos, exp_last_pos;

  int m_term, m_err, m_idx;
  bit m_fev, m_len, m_pass;

  always #5 clk = ~clk;

  axis_stream_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .act_next_data(act_next_data), .act_in(act_in), .act_valid(act_valid), .act_last(act_last),
    .exp_next_data(exp_next_data), .exp_in(exp_in), .exp_valid(exp_valid), .exp_last(exp_last),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_valid(first_err_valid), .length_err(length_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_pass"}, 64'(pass), 64'(0));
    check({tag, "_err_count"}, 64'(err_count), 64'(0));
    check({tag, "_first_err_idx"}, 64'(first_err_idx), 64'(0));
    check({tag, "_first_err_valid"}, 64'(first_err_valid), 64'(0));
    check({tag, "_length_err"}, 64'(length_err), 64'(0));
  endtask

  task automatic fill_streams();
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = $urandom;
      act_mem[i] = exp_mem[i];
    end
    act_last_pos = DEPTH - 1;
    exp_last_pos = DEPTH - 1;
  endtask

  // Expected run outcome: walk pairs until either stream ends or DEPTH is reached.
  task automatic model();
    bit al, el;
    m_err = 0; m_idx = 0; m_fev = 0; m_len = 0; m_term = DEPTH - 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (act_mem[i] != exp_mem[i]) begin
        if (m_err == 0) begin
          m_fev = 1;
          m_idx = i;
        end
        m_err++;
      end
      al = (i == act_last_pos);
      el = (i == exp_last_pos);
      if (al || el || i == DEPTH - 1) begin
        m_term = i;
        m_len  = (al != el) || (!al && !el);
        break;
      end
    end
    m_pass = (m_err == 0) && !m_len;
  endtask

  task automatic run(input string name, input bit gaps, input int restart_at, input int reset_at);
    int  xfers = 0;
    int  cycles = 0;
    bit  s;
    bit  restarted = 0;
    model();
    @(negedge clk);
    start = 1'b1; act_valid = 1'b0; exp_valid = 1'b0;
    @(posedge clk);
    while (1) begin
      @(negedge clk);
      check({name, "_done_low"}, 64'(done), 64'(0));
      check({name, "_busy"}, 64'(busy), 64'(1));
      if (reset_at >= 0 && xfers == reset_at) begin
        start = 1'b0;
        rst = 1'b0;
        #1;
        check_all_zero({name, "_in_reset"});
        repeat (3) begin
          @(negedge clk);
          check({name, "_reset_done"}, 64'(done), 64'(0));
        end
        rst = 1'b1;
        act_valid = 1'b0; exp_valid = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check({name, "_after_reset_done"}, 64'(done), 64'(0));
          check({name, "_after_reset_busy"}, 64'(busy), 64'(0));
        end
        return;
      end
      start = (restart_at >= 0 && xfers == restart_at && !restarted);
      if (start) restarted = 1;
      act_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      exp_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      act_in    = act_valid ? act_mem[xfers] : $urandom;
      exp_in    = exp_valid ? exp_mem[xfers] : $urandom;
      act_last  = (xfers == act_last_pos);
      exp_last  = (xfers == exp_last_pos);
      #1;
      s = act_valid && exp_valid;
      check({name, "_act_next_data"}, 64'(act_next_data), 64'(s));
      check({name, "_exp_next_data"}, 64'(exp_next_data), 64'(s));
      @(posedge clk);
      if (s) xfers++;
      cycles++;
      n_asserts++;
      assert (cycles < BUDGET) else begin
        n_fails++;
        $error("FAIL %s_watchdog observed=%0d transfers expected=%0d", name, xfers, m_term + 1);
        return;
      end
      if (xfers == m_term + 1) break;
    end
    @(negedge clk);
    start = 1'b0; act_valid = 1'b0; exp_valid = 1'b0;
    act_last = 1'b0; exp_last = 1'b0;
    check({name, "_done"}, 64'(done), 64'(1));
    check({name, "_busy_end"}, 64'(busy), 64'(0));
    check({name, "_pass"}, 64'(pass), 64'(m_pass));
    check({name, "_err_count"}, 64'(err_count), 64'(m_err));
    check({name, "_first_err_idx"}, 64'(first_err_idx), 64'(m_idx));
    check({name, "_first_err_valid"}, 64'(first_err_valid), 64'(m_fev));
    check({name, "_length_err"}, 64'(length_err), 64'(m_len));
    @(negedge clk);
    check({name, "_done_one_cycle"}, 64'(done), 64'(0));
    check({name, "_pass_hold"}, 64'(pass), 64'(m_pass));
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    fill_streams();
    run("identical", 0, -1, -1);

    fill_streams();
    exp_mem[5] = 32'h1234_5678;
    act_mem[5] = 32'hDEAD_BEEF;
    act_mem[9] = ~exp_mem[9];
    run("two_errors", 0, -1, -1);

    fill_streams();
    act_last_pos = 20;
    run("early_act_last", 0, -1, -1);

    fill_streams();
    run("valid_gaps", 1, -1, -1);

    fill_streams();
    run("abort_reset", 0, -1, 10);
    fill_streams();
    run("after_reset", 0, -1, -1);

    fill_streams();
    act_mem[7] = act_mem[7] ^ 32'h1;
    run("restart_ignored", 0, 4, -1);

    fill_streams();
    act_last_pos = 99;
    exp_last_pos = 99;
    act_mem[30] = act_mem[30] ^ 32'h8;
    run("overrun", 0, -1, -1);

    fill_streams();
    act_last_pos = 0;
    exp_last_pos = 0;
    run("single_word", 0, -1, -1);

    fill_streams();
    exp_last_pos = 3;
    act_mem[2] = ~act_mem[2];
    act_mem[3] = ~act_mem[3];
    run("gaps_exp_short", 1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
